// File: rtl/aes_iter_encrypt.sv
// Iterative AES encryptor: one cipher round per clock over a single state register.
// Round keys arrive pre-expanded; NK selects AES-128/192/256.
module aes_iter_encrypt #(
  parameter int unsigned NK    = 4,
  parameter int unsigned TAG_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [127:0]            in_data,
  input  logic [(NK+7)*128-1:0]   in_keys,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [127:0]            out_data,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    busy
);

  localparam int unsigned NR     = NK + 6;
  localparam int unsigned KEYS_W = (NR + 1) * 128;
  localparam int unsigned CTR_W  = $clog2(NR + 1);

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("aes_iter_encrypt: NK must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} fsm_t;

  fsm_t             fsm;
  logic [CTR_W-1:0] round_ctr;
  logic [127:0]     state_q;
  logic [127:0]     key_q [NR+1];
  logic [TAG_W-1:0] tag_q;
  logic [127:0]     shifted;
  logic [127:0]     mixed;
  logic [127:0]     round_out;
  logic             last_round;
  logic             accept;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] inv;
    p   = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Byte i sits at row i%4, column i/4; byte 0 is the MSB
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(row+4*c) -: 8] = sbox(s[127-8*(row+4*((c+row)%4)) -: 8]);
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  assign in_ready = (fsm == S_IDLE) | ((fsm == S_DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  // One full round datapath; the final round skips MixColumns
  always_comb begin
    last_round = (round_ctr == CTR_W'(NR));
    shifted    = sub_shift(state_q);
    mixed      = mix_columns(shifted);
    round_out  = (last_round ? shifted : mixed) ^ key_q[round_ctr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= S_IDLE;
      round_ctr <= '0;
      state_q   <= '0;
      tag_q     <= '0;
      for (int r = 0; r <= int'(NR); r++) key_q[r] <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      busy      <= 1'b0;
    end else if (accept) begin
      // Also covers DONE with a simultaneous consume: straight back to BUSY
      fsm       <= S_BUSY;
      round_ctr <= CTR_W'(1);
      state_q   <= in_data ^ in_keys[KEYS_W-1 -: 128];
      tag_q     <= in_tag;
      for (int r = 0; r <= int'(NR); r++) key_q[r] <= in_keys[KEYS_W-1-128*r -: 128];
      out_valid <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (fsm)
        S_BUSY: begin
          state_q <= round_out;
          if (last_round) begin
            fsm       <= S_DONE;
            round_ctr <= '0;
            out_data  <= round_out;
            out_tag   <= tag_q;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end else begin
            round_ctr <= round_ctr + CTR_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            fsm       <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          fsm <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iter_encrypt.sv
// Directed bench for aes_iter_encrypt: FIPS-197 vectors on NK=4/6/8 instances,
// backpressure, back-to-back streaming, key scrambling while busy, mid-flight reset.
module tb_aes_iter_encrypt;

  logic         clk;
  logic         rst_n;
  logic         iv  [3];
  logic         ir  [3];
  logic [127:0] id  [3];
  logic [1919:0] ik [3];
  logic [7:0]   it  [3];
  logic         ov  [3];
  logic         ordy[3];
  logic [127:0] od  [3];
  logic [7:0]   ot  [3];
  logic         bz  [3];

  int n_tests;
  int n_fail;

  localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] KEY_B   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY_C1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KEY_C2  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [127:0] CT_C2   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_iter_encrypt #(.NK(4), .TAG_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .in_keys(ik[0][1919 -: 1408]), .in_tag(it[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_data(od[0]), .out_tag(ot[0]), .busy(bz[0]));

  aes_iter_encrypt #(.NK(6), .TAG_W(8)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .in_keys(ik[1][1919 -: 1664]), .in_tag(it[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_data(od[1]), .out_tag(ot[1]), .busy(bz[1]));

  aes_iter_encrypt #(.NK(8), .TAG_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
    .in_keys(ik[2]), .in_tag(it[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_data(od[2]), .out_tag(ot[2]), .busy(bz[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] v;
    p = x;
    v = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      v = gmul(v, p);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  // Standard key schedule; round key r ends up at [1919-128*r -: 128]
  function automatic logic [1919:0] expand_keys(input logic [255:0] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] r;
    r  = '0;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
      r[1919-32*i -: 32] = w[i];
    end
    return r;
  endfunction

  // Offer one block, wait for accept, then count edges until out_valid (-1 on timeout)
  task automatic run_block(input int i, input logic [127:0] pt, input logic [255:0] key,
                           input int nk, input logic [7:0] tag, input bit scramble,
                           output int lat);
    int n;
    @(negedge clk);
    id[i] = pt;
    ik[i] = expand_keys(key, nk);
    it[i] = tag;
    iv[i] = 1'b1;
    n = 0;
    while (!ir[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    iv[i] = 1'b0;
    lat = 0;
    while (!ov[i] && lat < 100) begin
      if (scramble) begin
        id[i] = {$urandom, $urandom, $urandom, $urandom};
        it[i] = 8'($urandom);
        for (int w = 0; w < 60; w++) ik[i][32*w +: 32] = $urandom;
      end
      @(negedge clk);
      lat++;
    end
    if (!ov[i]) lat = -1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_tests++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", ov[0]); end
    n_tests++; if (bz[0] !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bz[0]); end
    n_tests++; if (od[0] !== 128'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", od[0]); end
    n_tests++; if (ot[0] !== 8'h0) begin n_fail++; $display("FAIL reset_out_tag got %h want 0", ot[0]); end
    n_tests++; if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", ir[0]); end
    rst_n = 1'b1;
  endtask

  task automatic test_fips128;
    int lat;
    run_block(0, PT_B, KEY_B, 4, 8'ha5, 1'b0, lat);
    n_tests++; if (lat !== 10) begin n_fail++; $display("FAIL aes128_latency got %0d want 10", lat); end
    n_tests++; if (od[0] !== CT_B) begin n_fail++; $display("FAIL aes128_data got %h want %h", od[0], CT_B); end
    n_tests++; if (ot[0] !== 8'ha5) begin n_fail++; $display("FAIL aes128_tag got %h want a5", ot[0]); end
    n_tests++; if (bz[0] !== 1'b0) begin n_fail++; $display("FAIL aes128_busy_done got %b want 0", bz[0]); end
    @(negedge clk);
    n_tests++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL aes128_consume got %b want 0", ov[0]); end
  endtask

  task automatic test_aes192_256;
    int lat;
    run_block(1, PT_C, KEY_C2, 6, 8'h06, 1'b0, lat);
    n_tests++; if (lat !== 12) begin n_fail++; $display("FAIL aes192_latency got %0d want 12", lat); end
    n_tests++; if (od[1] !== CT_C2) begin n_fail++; $display("FAIL aes192_data got %h want %h", od[1], CT_C2); end
    run_block(2, PT_C, KEY_C3, 8, 8'h08, 1'b0, lat);
    n_tests++; if (lat !== 14) begin n_fail++; $display("FAIL aes256_latency got %0d want 14", lat); end
    n_tests++; if (od[2] !== CT_C3) begin n_fail++; $display("FAIL aes256_data got %h want %h", od[2], CT_C3); end
  endtask

  task automatic test_backpressure;
    int lat;
    ordy[0] = 1'b0;
    run_block(0, PT_C, KEY_C1, 4, 8'h3c, 1'b0, lat);
    n_tests++; if (lat !== 10) begin n_fail++; $display("FAIL bp_latency got %0d want 10", lat); end
    for (int c = 0; c < 20; c++) begin
      iv[0] = 1'b1;
      id[0] = PT_B;
      n_tests++;
      if (ov[0] !== 1'b1 || od[0] !== CT_C1 || ot[0] !== 8'h3c || ir[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d got v=%b d=%h t=%h rdy=%b want v=1 d=%h t=3c rdy=0",
                 c, ov[0], od[0], ot[0], ir[0], CT_C1);
      end
      @(negedge clk);
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    @(negedge clk);
    n_tests++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL bp_release got %b want 0", ov[0]); end
    n_tests++; if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL bp_idle_ready got %b want 1", ir[0]); end
  endtask

  task automatic test_back_to_back;
    logic [127:0] pts  [4];
    logic [255:0] keys [4];
    logic [127:0] exps [4];
    int k_in, k_out, last;
    bit pend;
    pts[0] = PT_B; keys[0] = KEY_B;  exps[0] = CT_B;
    pts[1] = PT_C; keys[1] = KEY_C1; exps[1] = CT_C1;
    pts[2] = PT_B; keys[2] = KEY_B;  exps[2] = CT_B;
    pts[3] = PT_C; keys[3] = KEY_C1; exps[3] = CT_C1;
    @(negedge clk);
    ordy[0] = 1'b1;
    k_in = 0; k_out = 0; last = 0; pend = 1'b0;
    id[0] = pts[0]; ik[0] = expand_keys(keys[0], 4); it[0] = 8'd1; iv[0] = 1'b1;
    for (int cyc = 0; cyc < 100 && k_out < 4; cyc++) begin
      if (pend) begin
        pend = 1'b0;
        if (k_in < 4) begin
          id[0] = pts[k_in]; ik[0] = expand_keys(keys[k_in], 4); it[0] = 8'(k_in + 1);
        end else begin
          iv[0] = 1'b0;
        end
      end
      if (ov[0]) begin
        n_tests++;
        if (od[0] !== exps[k_out] || ot[0] !== 8'(k_out + 1)) begin
          n_fail++;
          $display("FAIL b2b_result %0d got d=%h t=%h want d=%h t=%h", k_out, od[0], ot[0], exps[k_out], 8'(k_out + 1));
        end
        if (k_out > 0) begin
          n_tests++;
          if (cyc - last !== 11) begin n_fail++; $display("FAIL b2b_interval %0d got %0d want 11", k_out, cyc - last); end
        end
        last = cyc;
        k_out++;
      end
      if (iv[0] && ir[0]) begin
        pend = 1'b1;
        k_in++;
      end
      @(negedge clk);
    end
    iv[0] = 1'b0;
    n_tests++; if (k_out !== 4) begin n_fail++; $display("FAIL b2b_count got %0d want 4", k_out); end
    @(negedge clk);
  endtask

  task automatic test_key_change;
    int lat;
    run_block(0, PT_B, KEY_B, 4, 8'h77, 1'b1, lat);
    n_tests++; if (lat !== 10) begin n_fail++; $display("FAIL keychg_latency got %0d want 10", lat); end
    n_tests++; if (od[0] !== CT_B) begin n_fail++; $display("FAIL keychg_data got %h want %h", od[0], CT_B); end
    n_tests++; if (ot[0] !== 8'h77) begin n_fail++; $display("FAIL keychg_tag got %h want 77", ot[0]); end
    @(negedge clk);
  endtask

  task automatic test_reset_midflight;
    int n;
    int lat;
    bit bad;
    @(negedge clk);
    id[0] = PT_C; ik[0] = expand_keys(KEY_C1, 4); it[0] = 8'h55; iv[0] = 1'b1;
    n = 0;
    while (!ir[0] && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++; if (bz[0] !== 1'b1) begin n_fail++; $display("FAIL rst_busy_before got %b want 1", bz[0]); end
    n_tests++; if (ir[0] !== 1'b0) begin n_fail++; $display("FAIL rst_ready_busy got %b want 0", ir[0]); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid got %b want 0", ov[0]); end
    n_tests++; if (bz[0] !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy got %b want 0", bz[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (ov[0] !== 1'b0 || ir[0] !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    n_tests++; if (bad) begin n_fail++; $display("FAIL rst_no_stale got stale output or in_ready low want quiet idle"); end
    run_block(0, PT_C, KEY_C1, 4, 8'h66, 1'b0, lat);
    n_tests++; if (lat !== 10) begin n_fail++; $display("FAIL rst_after_latency got %0d want 10", lat); end
    n_tests++; if (od[0] !== CT_C1) begin n_fail++; $display("FAIL rst_after_data got %h want %h", od[0], CT_C1); end
    n_tests++; if (ot[0] !== 8'h66) begin n_fail++; $display("FAIL rst_after_tag got %h want 66", ot[0]); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; id[i] = '0; ik[i] = '0; it[i] = '0; ordy[i] = 1'b1;
    end
    test_reset;
    test_fips128;
    test_aes192_256;
    test_backpressure;
    test_back_to_back;
    test_key_change;
    test_reset_midflight;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
